frame_motion_ctrl: RTL
======================

// Module: frame_motion_ctrl
// PURPOSE
//  Frame-synchronous motion sequencer for the on-screen box. It sits between vga_syncgen and disp_box.
//  It detects each frame start from vsync and debounces btn[3:0]. Once per frame it runs a short FSM
//  that computes the next box centre: bounce mode (auto_en=1) or button-steered mode (auto_en=0).
//  Position outputs change only at the COMMIT cycle, which falls inside vertical blanking. No tearing.
// PARAMETERS
//  H_RES          640     active pixels per line
//  V_RES          480     active lines per frame
//  SIZE           32      box edge length in pixels; must be even
//  STEP           2       pixels moved per frame per axis; 1..SIZE/2
//  DB_CYCLES      250000  debounce stability window in clk cycles (10 ms at 25 MHz)
//  VS_ACTIVE_LOW  1       1: vsync pulse is low-active; 0: high-active
// PORTS
//  clk       in   1   pixel clock, rising edge
//  rst       in   1   synchronous reset, active-high
//  vsync     in   1   vsync from vga_syncgen
//  btn       in   4   raw buttons, asynchronous: [0]=up [1]=down [2]=left [3]=right
//  auto_en   in   1   1=bounce mode, 0=button mode; sampled in CALC_X/CALC_Y
//  box_x     out  10  box centre x; box covers [box_x-SIZE/2, box_x+SIZE/2-1]
//  box_y     out  10  box centre y, same convention
//  dir_x     out  1   bounce direction x: 1=+x (right), 0=-x
//  dir_y     out  1   bounce direction y: 1=+y (down), 0=-y
//  bounce    out  1   1-cycle pulse at COMMIT if either axis hit a limit this frame
//  frame_tick out 1   1-cycle pulse on each vsync assertion edge
// BEHAVIOUR
//  Reset values: box_x=H_RES/2, box_y=V_RES/2, dir_x=1, dir_y=1, bounce=0, frame_tick=0.
//    Debounced buttons reset to 0. Debounce counters reset to 0. vs_q resets to the inactive level.
//    FSM resets to WAIT. Any calculation in flight is discarded.
//  Limits: XMIN=SIZE/2, XMAX=H_RES-SIZE/2, YMIN=SIZE/2, YMAX=V_RES-SIZE/2.
//    Internal arithmetic is 11-bit signed, so that pos-STEP below 0 is caught before clamping.
//  Frame tick: vs_q is vsync registered once. frame_tick=1 in the cycle where vs_q is inactive
//    and vsync is active. vsync is assumed already synchronous to clk.
//  Debounce, per bit: a 2-FF synchroniser feeds a counter.
//    - Counter clears whenever the synced value equals the debounced value.
//    - Otherwise it increments. At DB_CYCLES-1 the debounced value takes the synced value and the counter clears.
//  FSM: WAIT -> CALC_X -> CALC_Y -> COMMIT -> WAIT.
//    - WAIT: hold. Leave on frame_tick.
//    - CALC_X / CALC_Y: compute nx/ny and next dir/bounce flags into shadow registers.
//    - COMMIT: box_x/box_y/dir_x/dir_y take the shadow values, bounce pulses if flagged.
//    - Latency: outputs update 3 cycles after the frame_tick cycle.
//    - frame_tick outside WAIT is ignored; it cannot occur with legal VGA timing.
//  Bounce mode, per axis: n = pos + (dir ? +STEP : -STEP).
//    - If dir=1 and n>=MAX: n=MAX, dir:=0, flag bounce.
//    - If dir=0 and n<=MIN: n=MIN, dir:=1, flag bounce.
//    - Reaching a limit exactly counts as a bounce.
//  Button mode:
//    - x: right-only => +STEP; left-only => -STEP; both or neither => hold.
//    - y: down-only => +STEP; up-only => -STEP; both or neither => hold.
//    - Result is clamped to [MIN,MAX]. dir_* is unchanged. bounce is never asserted.
//  A mode switch mid-frame takes effect at the next CALC. Position is preserved across the switch.
// TESTING (sim params: H_RES=64 V_RES=48 SIZE=8 STEP=2 DB_CYCLES=4)
//  1. Reset held 2 cycles, then vsync toggled -> box=(32,24), dir=(1,1).
//     frame_tick pulses once per assertion edge; box changes exactly 3 cycles later.
//  2. auto_en=1, 14 frames from reset -> box_x: 34,36..60. At frame 14 box_x=60=XMAX, dir_x=0, bounce=1.
//     At frame 10 box_y hits YMAX=44: dir_y=0, bounce=1 that frame.
//  3. auto_en=0, btn[3] held steady -> no movement until debounced (after 6 clk incl. sync).
//     Then box_x +2 per frame, stops at 60. bounce stays 0.
//  4. btn[3] glitched high for 2 clk -> debounced value unchanged, box_x unchanged.
//     btn[0]+btn[1] held together -> box_y unchanged.
//  5. auto_en=0, btn[2] held until box_x=4 -> box_x clamps at XMIN=4.
//     Next frame must give 4, with no underflow to a value near 1023.
//  6. rst asserted in CALC_Y of a frame -> next cycle all outputs at reset values, FSM in WAIT.
//     The following frame_tick yields box=(34,26) in bounce mode.

Source files
------------

// File: rtl/frame_motion_ctrl.sv
// Frame-synchronous box motion sequencer.
// Detects frame start from vsync and debounces the four buttons. Once per frame a
// short FSM computes the next box centre, either bouncing or steered by buttons.
// Position and direction outputs are written only in COMMIT, inside vertical
// blanking. The new values are visible from the cycle after COMMIT, together
// with the bounce pulse.
module frame_motion_ctrl #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int SIZE          = 32,
  parameter int STEP          = 2,
  parameter int DB_CYCLES     = 250000,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic [3:0] btn,
  input  logic       auto_en,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       bounce,
  output logic       frame_tick
);

  localparam logic signed [10:0] XMIN   = 11'(SIZE / 2);
  localparam logic signed [10:0] XMAX   = 11'(H_RES - SIZE / 2);
  localparam logic signed [10:0] YMIN   = 11'(SIZE / 2);
  localparam logic signed [10:0] YMAX   = 11'(V_RES - SIZE / 2);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  localparam int              CW      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);

  localparam logic VS_ON = (VS_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  localparam logic [1:0] S_WAIT   = 2'd0;
  localparam logic [1:0] S_CALC_X = 2'd1;
  localparam logic [1:0] S_CALC_Y = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  // Saturate a signed coordinate into [lo, hi].
  function automatic logic signed [10:0] clamp(input logic signed [10:0] v,
                                               input logic signed [10:0] lo,
                                               input logic signed [10:0] hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

  // Bounce step for one axis: returns {hit_flag, new_dir, new_pos}.
  function automatic logic [11:0] bounce_step(input logic [9:0] pos,
                                              input logic       dir,
                                              input logic signed [10:0] lo,
                                              input logic signed [10:0] hi);
    logic signed [10:0] n;
    n = $signed({1'b0, pos}) + (dir ? STEP_S : -STEP_S);
    if (dir && (n >= hi))       return {1'b1, 1'b0, hi[9:0]};
    else if (!dir && (n <= lo)) return {1'b1, 1'b1, lo[9:0]};
    else                        return {1'b0, dir, n[9:0]};
  endfunction

  // Button step for one axis: move only when exactly one of plus/minus is held.
  function automatic logic [9:0] btn_step(input logic [9:0] pos,
                                          input logic       plus,
                                          input logic       minus,
                                          input logic signed [10:0] lo,
                                          input logic signed [10:0] hi);
    logic signed [10:0] n;
    logic signed [10:0] c;
    n = $signed({1'b0, pos});
    if (plus && !minus)      n = n + STEP_S;
    else if (minus && !plus) n = n - STEP_S;
    c = clamp(n, lo, hi);
    return c[9:0];
  endfunction

  logic                vs_q;
  logic [3:0]          sync1_q, sync2_q;
  logic [3:0]          db_q;
  logic [CW-1:0]       cnt_q [4];
  logic [1:0]          state_q, state_d;
  logic [9:0]          box_x_q, box_y_q;
  logic                dir_x_q, dir_y_q, bounce_q;
  logic [9:0]          nx_q, ny_q;
  logic                ndx_q, ndy_q, bx_q, by_q;
  logic [11:0]         ax_res, ay_res;
  logic [9:0]          x_btn, y_btn;

  assign frame_tick = !rst && (vs_q != VS_ON) && (vsync == VS_ON);

  // Register vsync once for assertion-edge detection.
  always_ff @(posedge clk) begin
    if (rst) vs_q <= ~VS_ON;
    else     vs_q <= vsync;
  end

  // Two-flop synchroniser for the asynchronous buttons.
  always_ff @(posedge clk) begin
    sync1_q <= btn;
    sync2_q <= sync1_q;
  end

  // Per-bit debounce: the synced value must differ for DB_CYCLES cycles to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          db_q[i]  <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Candidate next positions for both modes, from the committed position.
  always_comb begin
    ax_res = bounce_step(box_x_q, dir_x_q, XMIN, XMAX);
    ay_res = bounce_step(box_y_q, dir_y_q, YMIN, YMAX);
    x_btn  = btn_step(box_x_q, db_q[3], db_q[2], XMIN, XMAX);
    y_btn  = btn_step(box_y_q, db_q[1], db_q[0], YMIN, YMAX);
  end

  // Sequencer next-state: one pass WAIT -> CALC_X -> CALC_Y -> COMMIT per frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (frame_tick) state_d = S_CALC_X;
      S_CALC_X: state_d = S_CALC_Y;
      S_CALC_Y: state_d = S_COMMIT;
      default:  state_d = S_WAIT;
    endcase
  end

  // Shadow registers hold the computed frame update until COMMIT.
  always_ff @(posedge clk) begin
    if (state_q == S_CALC_X) begin
      if (auto_en) begin
        {bx_q, ndx_q, nx_q} <= ax_res;
      end else begin
        nx_q  <= x_btn;
        ndx_q <= dir_x_q;
        bx_q  <= 1'b0;
      end
    end
    if (state_q == S_CALC_Y) begin
      if (auto_en) begin
        {by_q, ndy_q, ny_q} <= ay_res;
      end else begin
        ny_q  <= y_btn;
        ndy_q <= dir_y_q;
        by_q  <= 1'b0;
      end
    end
  end

  // FSM state and committed outputs; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT;
      box_x_q  <= 10'(H_RES / 2);
      box_y_q  <= 10'(V_RES / 2);
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      bounce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bounce_q <= (state_q == S_COMMIT) && (bx_q || by_q);
      if (state_q == S_COMMIT) begin
        box_x_q <= nx_q;
        box_y_q <= ny_q;
        dir_x_q <= ndx_q;
        dir_y_q <= ndy_q;
      end
    end
  end

  assign box_x  = box_x_q;
  assign box_y  = box_y_q;
  assign dir_x  = dir_x_q;
  assign dir_y  = dir_y_q;
  assign bounce = bounce_q;

endmodule
